wave_capture: RTL and testbench

- Sits directly downstream of the music player and consumes its sample stream: new_sample_generated pulses plus the 18-bit sample_out.
- Triggers on a positive-going zero crossing, then records 256 consecutive samples, reduced to 8 bits each, into a double-buffered waveform RAM.
- The wave display reads one bank while capture writes the other.
- Banks swap only when the display reports it is idle between frames, so a half-written waveform is never displayed.

---
 rtl/wave_capture_if.sv | 27 ++
 rtl/wave_capture.sv | 110 +++++++++++
 tb/tb_wave_capture.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_if.sv
// Sample-stream and waveform-RAM write signals between the music player,
// the wave display and the capture block.
interface wave_capture_if #(
  parameter int unsigned SAMPLE_W = 18,
  parameter int unsigned ADDR_W   = 8
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [7:0]          write_sample;
  logic                read_index;
  logic [1:0]          capture_state;

  // Producer/display side: drives samples and idle, observes RAM writes.
  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index, capture_state
  );

  // Capture block side.
  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index, capture_state
  );
endinterface

// File: rtl/wave_capture.sv
// Zero-crossing triggered waveform capture into a double-buffered RAM.
// Capture writes bank ~read_index; banks swap only while the display is idle.
module wave_capture #(
  parameter int unsigned SAMPLE_W = 18,
  parameter int unsigned ADDR_W   = 8
) (
  input logic           clk,
  input logic           reset,
  wave_capture_if.slave bus
);

  typedef enum logic [1:0] {
    StArmed  = 2'd0,
    StActive = 2'd1,
    StWait   = 2'd2
  } state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_count, w_count_next;
  logic                r_prev_neg;
  logic                r_read_index, w_read_index_next;
  logic                r_wr_en, w_wr_en_next;
  logic [ADDR_W:0]     r_wr_addr, w_wr_addr_next;
  logic [7:0]          r_wr_sample, w_wr_sample_next;

  logic                w_sample_neg;
  logic                w_crossing;
  logic [7:0]          w_reduced;

  assign w_sample_neg = bus.new_sample_in[SAMPLE_W-1];
  assign w_crossing   = bus.new_sample_ready & r_prev_neg & ~w_sample_neg;
  // Offset binary: top 8 bits with the sign inverted, so 0 maps to mid-scale.
  assign w_reduced    = {~w_sample_neg, bus.new_sample_in[SAMPLE_W-2 -: 7]};

  // Next-state, counter, bank swap and registered-write decisions.
  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_read_index_next = r_read_index;
    w_wr_en_next      = 1'b0;
    w_wr_addr_next    = r_wr_addr;
    w_wr_sample_next  = r_wr_sample;
    unique case (r_state)
      StArmed: begin
        if (w_crossing) begin
          w_wr_en_next     = 1'b1;
          w_wr_addr_next   = {~r_read_index, {ADDR_W{1'b0}}};
          w_wr_sample_next = w_reduced;
          w_count_next     = ADDR_W'(1);
          w_state_next     = StActive;
        end
      end
      StActive: begin
        if (bus.new_sample_ready) begin
          w_wr_en_next     = 1'b1;
          w_wr_addr_next   = {~r_read_index, r_count};
          w_wr_sample_next = w_reduced;
          w_count_next     = r_count + ADDR_W'(1);
          if (r_count == {ADDR_W{1'b1}}) begin
            w_count_next = '0;
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        // Swap only between display frames so a partial capture is never shown.
        if (bus.wave_display_idle) begin
          w_read_index_next = ~r_read_index;
          w_state_next      = StArmed;
        end
      end
      default: w_state_next = StArmed;
    endcase
  end

  // State, counter, bank and write-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StArmed;
      r_count      <= '0;
      r_read_index <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_sample  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_read_index <= w_read_index_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_sample  <= w_wr_sample_next;
    end
  end

  // Sign of the last sample seen, tracked in every state for crossing detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_neg <= 1'b0;
    end else if (bus.new_sample_ready) begin
      r_prev_neg <= w_sample_neg;
    end
  end

  assign bus.write_enable  = r_wr_en;
  assign bus.write_address = r_wr_addr;
  assign bus.write_sample  = r_wr_sample;
  assign bus.read_index    = r_read_index;
  assign bus.capture_state = r_state;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed table, multi-cycle sequences
// and randomized traffic against a sample-level reference model.
module tb_wave_capture;

  logic clk;
  logic reset;

  wave_capture_if #(.SAMPLE_W(18), .ADDR_W(8)) bus ();

  wave_capture #(.SAMPLE_W(18), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: phase 0=armed 1=capturing 2=waiting, n = samples taken.
  int         m_phase;
  int         m_n;
  bit         m_bank;
  bit         m_prev_neg;
  bit         m_we;
  logic [8:0] m_addr;
  logic [7:0] m_smp;

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_bank = 0; m_prev_neg = 0;
    m_we = 0; m_addr = '0; m_smp = '0;
  endtask

  task automatic model_step(input bit rdy, input int s, input bit idle);
    m_we = 0;
    if (m_phase == 2) begin
      if (idle) begin
        m_bank  = ~m_bank;
        m_phase = 0;
      end
    end else if (rdy && (m_phase == 1 || (m_prev_neg && s >= 0))) begin
      m_we    = 1;
      m_addr  = {~m_bank, 8'(m_n)};
      m_smp   = 8'((s + 131072) / 1024);
      m_n     = m_n + 1;
      m_phase = 1;
      if (m_n == 256) begin
        m_phase = 2;
        m_n     = 0;
      end
    end
    if (rdy) m_prev_neg = (s < 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare against the model.
  task automatic cycle(input bit rdy, input int s, input bit idle);
    logic [17:0] s18;
    s18 = s[17:0];
    bus.new_sample_ready  = rdy;
    bus.new_sample_in     = s18;
    bus.wave_display_idle = idle;
    @(posedge clk);
    model_step(rdy, s, idle);
    @(negedge clk);
    chk("model_we",    32'(bus.write_enable),  32'(m_we));
    chk("model_addr",  32'(bus.write_address), 32'(m_addr));
    chk("model_smp",   32'(bus.write_sample),  32'(m_smp));
    chk("model_state", 32'(bus.capture_state), 32'(m_phase));
    chk("model_bank",  32'(bus.read_index),    32'(m_bank));
    bus.new_sample_ready = 1'b0;
  endtask

  typedef struct {
    bit         rdy;
    int         s;
    bit         idle;
    bit         we;
    logic [8:0] addr;
    logic [7:0] smp;
    logic [1:0] st;
    bit         ri;
  } vec_t;

  vec_t vecs[7];
  int   writes;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{1, 5,    0, 0, 9'h000, 8'h00, 2'd0, 0};
    vecs[1] = '{1, 9,    0, 0, 9'h000, 8'h00, 2'd0, 0};
    vecs[2] = '{1, 2,    1, 0, 9'h000, 8'h00, 2'd0, 0};  // idle ignored in ARMED
    vecs[3] = '{0, -5,   0, 0, 9'h000, 8'h00, 2'd0, 0};  // no pulse: sign not tracked
    vecs[4] = '{1, -3,   0, 0, 9'h000, 8'h00, 2'd0, 0};
    vecs[5] = '{1, 0,    1, 1, 9'h100, 8'h80, 2'd1, 0};  // exact 0 triggers
    vecs[6] = '{0, 0,    0, 0, 9'h100, 8'h80, 2'd1, 0};  // outputs hold

    reset = 1'b0;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(bus.write_enable),  0);
    chk("rst_addr",  32'(bus.write_address), 0);
    chk("rst_smp",   32'(bus.write_sample),  0);
    chk("rst_state", 32'(bus.capture_state), 0);
    chk("rst_ri",    32'(bus.read_index),    0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].rdy, vecs[i].s, vecs[i].idle);
      chk($sformatf("vec%0d_we", i),    32'(bus.write_enable),  32'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i),  32'(bus.write_address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_smp", i),   32'(bus.write_sample),  32'(vecs[i].smp));
      chk($sformatf("vec%0d_state", i), 32'(bus.capture_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ri", i),    32'(bus.read_index),    32'(vecs[i].ri));
    end

    // Rest of the capture: 255 back-to-back ramp samples.
    for (int k = 1; k < 256; k++) begin
      cycle(1, k * 512, 0);
      chk("ramp_we",   32'(bus.write_enable),  1);
      chk("ramp_addr", 32'(bus.write_address), 32'(9'h100 + k));
      chk("ramp_smp",  32'(bus.write_sample),  32'(128 + k / 2));
    end
    chk("full_state", 32'(bus.capture_state), 2);
    cycle(1, -1000, 0);
    chk("wait_nowr", 32'(bus.write_enable), 0);
    cycle(1, 1000, 0);  // positive after negative: no trigger while waiting
    chk("wait_notrig", 32'(bus.write_enable), 0);

    repeat (1000) cycle(0, 0, 0);
    chk("hold_state", 32'(bus.capture_state), 2);
    chk("hold_ri",    32'(bus.read_index),    0);
    cycle(0, 0, 1);
    chk("swap_ri",    32'(bus.read_index),    1);
    chk("swap_state", 32'(bus.capture_state), 0);

    cycle(1, -1, 0);
    chk("neg1_we", 32'(bus.write_enable), 0);
    cycle(1, -200, 0);
    chk("neg200_we", 32'(bus.write_enable), 0);
    cycle(1, 7, 0);
    chk("pos7_we",   32'(bus.write_enable),  1);
    chk("pos7_addr", 32'(bus.write_address), 32'(9'h000));
    chk("pos7_smp",  32'(bus.write_sample),  32'(8'h80));

    // 99 more writes (count reaches 100) with a gap, then async reset mid-capture.
    for (int k = 0; k < 99; k++) begin
      cycle(1, int'($urandom_range(0, 262143)) - 131072, 0);
      chk("b2b_we", 32'(bus.write_enable), 1);
      if (k == 50) cycle(0, 0, 1);
    end
    chk("pre_rst_addr", 32'(bus.write_address), 32'(9'h063));
    #2 reset = 1'b0;
    #1;
    chk("arst_we",    32'(bus.write_enable),  0);
    chk("arst_addr",  32'(bus.write_address), 0);
    chk("arst_smp",   32'(bus.write_sample),  0);
    chk("arst_state", 32'(bus.capture_state), 0);
    chk("arst_ri",    32'(bus.read_index),    0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1, -1, 0);
    chk("rs_neg_we", 32'(bus.write_enable), 0);
    cycle(1, 1, 0);
    chk("rs_we",   32'(bus.write_enable),  1);
    chk("rs_addr", 32'(bus.write_address), 32'(9'h100));
    chk("rs_smp",  32'(bus.write_sample),  32'(8'h80));
    cycle(1, 2, 0);
    chk("rs_addr2", 32'(bus.write_address), 32'(9'h101));

    // Randomized traffic: bursts, gaps, small-magnitude samples to cross often.
    writes = 0;
    for (int c = 0; c < 8000; c++) begin
      bit rdy;
      bit idle;
      int s;
      rdy  = ($urandom_range(0, 9) < 7);
      idle = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 262143)) - 131072;
      else s = int'($urandom_range(0, 40)) - 20;
      cycle(rdy, s, idle);
      if (bus.write_enable) writes++;
    end
    chk("rand_activity", 32'(writes > 512), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
